// File: rtl/rv32_mc_ctrl.sv
// rtl/rv32_mc_ctrl.sv - multi-cycle control FSM for the RV32I core
//
// Purpose:
//   Sequences FETCH -> DECODE -> EXEC -> (MEM) -> WB for each instruction. It
//   selects the immediate format from the latched opcode and drives the IR, PC
//   and register-file write strobes and the imem/dmem request handshakes. An
//   illegal opcode or a memory wait of TIMEOUT cycles parks the FSM in TRAP
//   until reset.
//
// Ports:
//   i_clk            system clock, all state on rising edge
//   i_rst            synchronous active-high reset
//   i_inst[31:0]     instruction word from IR (valid from DECODE onward)
//   i_imem_ready     instruction memory has data for the current fetch
//   i_dmem_ready     data memory completed the current load
//   i_branch_taken   ALU compare result, sampled in EXEC
//   o_imem_req       fetch request, held while waiting in FETCH
//   o_ir_we          1-cycle IR load strobe
//   o_imm_control    00=I, 01=B, 10=J, 11=none
//   o_alu_src_imm    ALU operand B = immediate
//   o_dmem_req       load request, held while waiting in MEM
//   o_reg_we         1-cycle register-file write strobe
//   o_wb_sel         00=ALU, 01=dmem data, 10=PC+4
//   o_pc_we          1-cycle PC update strobe
//   o_pc_sel         0=PC+4, 1=ALU target
//   o_retire         1-cycle instruction-complete pulse
//   o_trap           sticky error flag
module rv32_mc_ctrl #(
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_inst,
  input  logic        i_imem_ready,
  input  logic        i_dmem_ready,
  input  logic        i_branch_taken,
  output logic        o_imem_req,
  output logic        o_ir_we,
  output logic [1:0]  o_imm_control,
  output logic        o_alu_src_imm,
  output logic        o_dmem_req,
  output logic        o_reg_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_pc_we,
  output logic        o_pc_sel,
  output logic        o_retire,
  output logic        o_trap
);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_OP  = 7'b0110011;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_wait;
  logic [6:0]      r_opcode;
  logic [1:0]      r_imm;
  logic            r_pc_sel;

  logic            w_wait_inc;
  logic [1:0]      w_imm_dec;
  logic            w_legal;
  logic            w_pc_sel_nxt;
  logic            w_imem_req;
  logic            w_ir_we;
  logic            w_alu_src_imm;
  logic            w_dmem_req;
  logic            w_reg_we;
  logic [1:0]      w_wb_sel;
  logic            w_pc_we;
  logic            w_retire;
  logic            w_trap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_FETCH;
      r_wait   <= '0;
      r_opcode <= '0;
      r_imm    <= 2'b11;
      r_pc_sel <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counter restarts on every state change, so it only ever measures the
      // current wait in FETCH or MEM.
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (w_wait_inc) begin
        r_wait <= r_wait + 1'b1;
      end
      if (r_state == S_DECODE) begin
        r_opcode <= i_inst[6:0];
        r_imm    <= w_imm_dec;
      end
      if (r_state == S_EXEC) begin
        r_pc_sel <= w_pc_sel_nxt;
      end
    end
  end

  always_comb begin
    w_imm_dec = 2'b11;
    w_legal   = 1'b1;
    case (i_inst[6:0])
      OP_IMM, OP_LD, OP_JLR: w_imm_dec = 2'b00;
      OP_BR:                 w_imm_dec = 2'b01;
      OP_JAL:                w_imm_dec = 2'b10;
      OP_OP:                 w_imm_dec = 2'b11;
      default:               w_legal   = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_sel_nxt = 1'b0;
    if ((r_opcode == OP_JAL) || (r_opcode == OP_JLR)) begin
      w_pc_sel_nxt = 1'b1;
    end else if (r_opcode == OP_BR) begin
      w_pc_sel_nxt = i_branch_taken;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_wait_inc    = 1'b0;
    w_imem_req    = 1'b0;
    w_ir_we       = 1'b0;
    w_alu_src_imm = 1'b0;
    w_dmem_req    = 1'b0;
    w_reg_we      = 1'b0;
    w_wb_sel      = 2'b00;
    w_pc_we       = 1'b0;
    w_retire      = 1'b0;
    w_trap        = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        // Ready wins over a counter that has just reached TIMEOUT.
        if (i_imem_ready) begin
          w_ir_we = 1'b1;
          w_next  = S_DECODE;
        end else if (r_wait == TO_MAX) begin
          w_next = S_TRAP;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        w_next = w_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        w_alu_src_imm = (r_opcode != OP_OP);
        w_next        = (r_opcode == OP_LD) ? S_MEM : S_WB;
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        if (i_dmem_ready) begin
          w_next = S_WB;
        end else if (r_wait == TO_MAX) begin
          w_next = S_TRAP;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_WB: begin
        w_pc_we  = 1'b1;
        w_retire = 1'b1;
        w_reg_we = (r_opcode != OP_BR);
        if (r_opcode == OP_LD) begin
          w_wb_sel = 2'b01;
        end else if ((r_opcode == OP_JAL) || (r_opcode == OP_JLR)) begin
          w_wb_sel = 2'b10;
        end
        w_next = S_FETCH;
      end
      S_TRAP: begin
        w_trap = 1'b1;
      end
      default: begin
        w_next = S_TRAP;
      end
    endcase
  end

  // While reset is held every request and strobe is forced low, so an
  // in-flight fetch or load is dropped in the reset cycle itself.
  assign o_imem_req    = w_imem_req    & ~i_rst;
  assign o_ir_we       = w_ir_we       & ~i_rst;
  assign o_imm_control = i_rst ? 2'b11 : r_imm;
  assign o_alu_src_imm = w_alu_src_imm & ~i_rst;
  assign o_dmem_req    = w_dmem_req    & ~i_rst;
  assign o_reg_we      = w_reg_we      & ~i_rst;
  assign o_wb_sel      = i_rst ? 2'b00 : w_wb_sel;
  assign o_pc_we       = w_pc_we       & ~i_rst;
  assign o_pc_sel      = r_pc_sel      & ~i_rst;
  assign o_retire      = w_retire      & ~i_rst;
  assign o_trap        = w_trap        & ~i_rst;

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// tb/tb_rv32_mc_ctrl.sv - directed self-checking bench for rv32_mc_ctrl
module tb_rv32_mc_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_inst;
  logic        i_imem_ready;
  logic        i_dmem_ready;
  logic        i_branch_taken;
  logic        o_imem_req;
  logic        o_ir_we;
  logic [1:0]  o_imm_control;
  logic        o_alu_src_imm;
  logic        o_dmem_req;
  logic        o_reg_we;
  logic [1:0]  o_wb_sel;
  logic        o_pc_we;
  logic        o_pc_sel;
  logic        o_retire;
  logic        o_trap;

  int n_chk = 0;
  int n_err = 0;

  rv32_mc_ctrl #(.TIMEOUT(200), .TO_W(8)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_inst         (i_inst),
    .i_imem_ready   (i_imem_ready),
    .i_dmem_ready   (i_dmem_ready),
    .i_branch_taken (i_branch_taken),
    .o_imem_req     (o_imem_req),
    .o_ir_we        (o_ir_we),
    .o_imm_control  (o_imm_control),
    .o_alu_src_imm  (o_alu_src_imm),
    .o_dmem_req     (o_dmem_req),
    .o_reg_we       (o_reg_we),
    .o_wb_sel       (o_wb_sel),
    .o_pc_we        (o_pc_we),
    .o_pc_sel       (o_pc_sel),
    .o_retire       (o_retire),
    .o_trap         (o_trap)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Must be entered in a FETCH cycle; returns in the following FETCH cycle.
  task automatic do_insn(input string tag, input logic [31:0] ins, input logic br,
                         input int dly, input logic [1:0] e_imm, input logic e_alu,
                         input logic [1:0] e_wb, input logic e_pcsel,
                         input logic e_regwe, input int e_lat, input int e_req);
    int cyc_n;
    int req_n;
    i_inst         = ins;
    i_imem_ready   = 1'b1;
    i_dmem_ready   = 1'b0;
    i_branch_taken = br;
    #1;
    check({tag, ".ir_we"}, o_ir_we, 1);
    check({tag, ".imem_req"}, o_imem_req, 1);
    step();
    check({tag, ".dec_ir_we"}, o_ir_we, 0);
    step();
    check({tag, ".imm"}, o_imm_control, e_imm);
    check({tag, ".alu_src"}, o_alu_src_imm, e_alu);
    cyc_n = 3;
    req_n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      cyc_n++;
      if (o_dmem_req) begin
        req_n++;
        i_dmem_ready = (req_n > dly);
        #1;
      end else begin
        i_dmem_ready = 1'b0;
      end
      if (o_retire) break;
    end
    check({tag, ".retire"}, o_retire, 1);
    check({tag, ".latency"}, cyc_n, e_lat);
    check({tag, ".dmem_req_cycles"}, req_n, e_req);
    check({tag, ".pc_we"}, o_pc_we, 1);
    check({tag, ".reg_we"}, o_reg_we, e_regwe);
    check({tag, ".wb_sel"}, o_wb_sel, e_wb);
    check({tag, ".pc_sel"}, o_pc_sel, e_pcsel);
    i_dmem_ready = 1'b0;
    step();
    check({tag, ".retire_1cyc"}, o_retire, 0);
    check({tag, ".pc_we_1cyc"}, o_pc_we, 0);
    check({tag, ".next_fetch"}, o_imem_req, 1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    #1;
  endtask

  initial begin
    i_rst          = 1'b1;
    i_inst         = 32'h0;
    i_imem_ready   = 1'b0;
    i_dmem_ready   = 1'b0;
    i_branch_taken = 1'b0;
    step();
    step();
    check("rst.imem_req", o_imem_req, 0);
    check("rst.imm", o_imm_control, 2'b11);
    check("rst.trap", o_trap, 0);
    check("rst.retire", o_retire, 0);
    i_rst = 1'b0;

    // tag, inst, br, dly, imm, alu_src, wb_sel, pc_sel, reg_we, latency, dmem cycles
    do_insn("addi", 32'h00500093, 1'b0, 0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 4, 0);
    do_insn("beq_t", 32'h00000463, 1'b1, 0, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 4, 0);
    do_insn("beq_nt", 32'h00000463, 1'b0, 0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 4, 0);
    do_insn("lw_d3", 32'h0000a103, 1'b0, 3, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 8, 4);
    do_insn("lw_d0", 32'h0000a103, 1'b0, 0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 5, 1);
    do_insn("jal", 32'h008000ef, 1'b0, 0, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 4, 0);
    do_insn("jalr", 32'h000080e7, 1'b0, 0, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 4, 0);
    do_insn("add", 32'h002081b3, 1'b0, 0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 4, 0);

    // Fetch timeout: counter reaches 200 after 200 unready cycles.
    i_imem_ready = 1'b0;
    i_inst       = 32'h00500093;
    for (int k = 0; k < 200; k++) step();
    check("to.no_trap_yet", o_trap, 0);
    check("to.still_req", o_imem_req, 1);
    step();
    check("to.trap", o_trap, 1);
    check("to.req_dropped", o_imem_req, 0);
    i_imem_ready = 1'b1;
    step();
    step();
    check("to.sticky", o_trap, 1);
    check("to.no_ir_we", o_ir_we, 0);
    do_reset();
    check("to.rst_clear", o_trap, 0);
    check("to.rst_fetch", o_imem_req, 1);

    // Ready arriving exactly when the counter reaches TIMEOUT wins.
    i_imem_ready = 1'b0;
    for (int k = 0; k < 200; k++) step();
    i_imem_ready = 1'b1;
    #1;
    check("edge.ir_we", o_ir_we, 1);
    step();
    check("edge.no_trap", o_trap, 0);
    step();
    step();
    check("edge.retire", o_retire, 1);
    step();

    // Illegal store opcode traps straight out of DECODE.
    i_inst = 32'h00000023;
    #1;
    check("ill.ir_we", o_ir_we, 1);
    step();
    step();
    check("ill.trap", o_trap, 1);
    check("ill.reg_we", o_reg_we, 0);
    check("ill.pc_we", o_pc_we, 0);
    check("ill.retire", o_retire, 0);
    step();
    check("ill.sticky", o_trap, 1);
    do_reset();
    check("ill.rst_clear", o_trap, 0);

    // Reset while waiting in MEM abandons the load.
    i_inst       = 32'h0000a103;
    i_imem_ready = 1'b1;
    i_dmem_ready = 1'b0;
    step();
    step();
    step();
    check("rmem.dmem_req", o_dmem_req, 1);
    i_rst = 1'b1;
    #1;
    check("rmem.req_in_rst", o_dmem_req, 0);
    step();
    i_rst = 1'b0;
    #1;
    check("rmem.fetch", o_imem_req, 1);
    check("rmem.dmem_req_off", o_dmem_req, 0);
    do_insn("post_rst", 32'h00500093, 1'b0, 0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 4, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
